// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        EVEN  = 2'd1,
        ODD   = 2'd2,
        NONE3 = 2'd3
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time divider: while running, pulses tick on the last cycle of every DIV-cycle bit.
module uart_baud_tick #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: combinational blocks assign every output first so no path leaves a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state updates use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: input FIFO feeding a start/data/parity/stop serialiser with registered txd.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int BW  = $clog2(DATA_BITS);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_param: CLK_HZ/BAUD gives a divider below 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // ---------------- input FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    assign in_ready = (level_q != LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem_q[rd_ptr_q];

    // NOTE: storage is not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------- serialiser ----------------
    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 par_q, par_d;
    logic                 has_par_q, has_par_d;
    logic                 stop2_q, stop2_d;
    logic                 txd_q, txd_d;
    logic                 tick;
    parity_t              pmode;

    assign pmode = parity_t'(parity_mode);

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (pop),
        .run   (state_q != IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_d     = bit_q;
        par_d     = par_q;
        has_par_d = has_par_q;
        stop2_d   = stop2_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (level_q != '0) pop = 1'b1;
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = has_par_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                // bit_q doubles as the stop-bit index; the last one ends the frame.
                if (tick) begin
                    if (bit_q == BW'(stop2_q)) begin
                        bit_d = '0;
                        if (level_q != '0) pop = 1'b1;
                        else               state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping loads the next frame and freezes its line configuration.
        if (pop) begin
            shift_d   = head;
            par_d     = (^head) ^ (pmode == ODD);
            has_par_d = (pmode == EVEN) || (pmode == ODD);
            stop2_d   = stop2;
            bit_d     = '0;
            state_d   = START;
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            PARITY:  txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            par_q     <= 1'b0;
            has_par_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            has_par_q <= has_par_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at DIV = 10 with 8-bit and 5-bit instances.
module tb_uart_tx_param;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] parity_mode;
    logic       stop2;

    logic       in_valid8, in_ready8, txd8, busy8;
    logic [7:0] in_data8;
    logic [2:0] level8;
    logic       in_valid5, in_ready5, txd5, busy5;
    logic [4:0] in_data5;
    logic [2:0] level5;

    logic       use5 = 1'b0;
    logic       txd_m, busy_m;
    logic [2:0] level_m;
    logic       acc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign txd_m   = use5 ? txd5   : txd8;
    assign busy_m  = use5 ? busy5  : busy8;
    assign level_m = use5 ? level5 : level8;

    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .parity_mode(parity_mode), .stop2(stop2),
        .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
        .txd(txd8), .busy(busy8), .fifo_level(level8)
    );

    uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .parity_mode(parity_mode), .stop2(stop2),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .txd(txd5), .busy(busy5), .fifo_level(level5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one word for one cycle; acc reports in_ready while it was presented.
    task automatic push(input logic sel, input logic [8:0] data, output logic ok);
        @(negedge clk);
        if (sel) begin
            in_valid5 = 1'b1;
            in_data5  = data[4:0];
        end else begin
            in_valid8 = 1'b1;
            in_data8  = data[7:0];
        end
        ok = sel ? in_ready5 : in_ready8;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        in_valid8 = 1'b0;
    endtask

    // Two idle-high cycles between acceptance and the start bit.
    task automatic expect_lead(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("%s lead%0d txd", tag, i), 32'(txd_m), 1);
        end
    endtask

    // frame[0] is the start bit; every bit must hold for DIV consecutive cycles.
    task automatic expect_frame(input string tag, input logic [15:0] frame, input int len,
                                input int exp_level);
        int hits;
        for (int b = 0; b < len; b++) begin
            hits = 0;
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                if (txd_m === frame[b]) hits++;
                if (b == 0 && c == DIV / 2) begin
                    check($sformatf("%s busy start", tag), 32'(busy_m), 1);
                    check($sformatf("%s level", tag), 32'(level_m), 32'(exp_level));
                end
                if (b == len - 1 && c == DIV / 2)
                    check($sformatf("%s busy stop", tag), 32'(busy_m), 1);
            end
            check($sformatf("%s bit%0d cycles", tag, b), 32'(hits), DIV);
        end
    endtask

    task automatic expect_idle(input string tag, input int n);
        int hits;
        hits = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (txd_m === 1'b1) hits++;
        end
        check($sformatf("%s idle high", tag), 32'(hits), 32'(n));
        check($sformatf("%s busy after", tag), 32'(busy_m), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        in_valid8   = 1'b0;
        in_data8    = '0;
        in_valid5   = 1'b0;
        in_data5    = '0;

        #12;
        check("rst txd",      32'(txd8),      1);
        check("rst busy",     32'(busy8),     0);
        check("rst in_ready", 32'(in_ready8), 1);
        check("rst level",    32'(level8),    0);
        check("rst txd5",     32'(txd5),      1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1
        push(1'b0, 9'h0A5, acc);
        check("a5 accepted", 32'(acc), 1);
        check("a5 level", 32'(level8), 1);
        check("a5 busy", 32'(busy8), 1);
        expect_lead("a5");
        expect_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 0);
        expect_idle("a5", 5);

        // Even parity, 0x07 has three ones -> parity bit 1.
        parity_mode = 2'd1;
        push(1'b0, 9'h007, acc);
        expect_lead("even");
        expect_frame("even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
        expect_idle("even", 5);

        // Odd parity -> parity bit 0, then two stop bits.
        parity_mode = 2'd2;
        stop2       = 1'b1;
        push(1'b0, 9'h007, acc);
        expect_lead("odd2");
        expect_frame("odd2", {4'b0, 2'b11, 1'b0, 8'h07, 1'b0}, 12, 0);
        expect_idle("odd2", 5);
        parity_mode = 2'd0;
        stop2       = 1'b0;

        // Six consecutive pushes: five accepted, sixth refused, five gapless frames.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(1'b0, 9'(8'h11 * (i + 1)), acc);
                    check($sformatf("b2b accept%0d", i), 32'(acc), (i < 5) ? 1 : 0);
                    if (i == 4) check("b2b level full", 32'(level8), 4);
                end
                check("b2b level after refuse", 32'(level8), 4);
                check("b2b in_ready full", 32'(in_ready8), 0);
            end
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                expect_lead("b2b");
                for (int k = 0; k < 5; k++)
                    expect_frame($sformatf("b2b f%0d", k),
                                 {6'b0, 1'b1, 8'(8'h11 * (k + 1)), 1'b0}, 10, 4 - k);
                expect_idle("b2b", 30);
            end
        join

        // Parity enabled mid-frame: frame 1 plain, frame 2 (0x5B, five ones) gets parity 1.
        fork
            begin
                push(1'b0, 9'h03C, acc);
                push(1'b0, 9'h05B, acc);
                repeat (30) @(posedge clk);
                parity_mode = 2'd1;
            end
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                expect_lead("cfg");
                expect_frame("cfg f0", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1);
                expect_frame("cfg f1", {5'b0, 1'b1, 1'b1, 8'h5B, 1'b0}, 11, 0);
                expect_idle("cfg", 5);
            end
        join
        parity_mode = 2'd0;

        // Five data bits, 0x13: line 0,1,1,0,0,1,1
        use5 = 1'b1;
        push(1'b1, 9'h013, acc);
        check("d5 level", 32'(level5), 1);
        expect_lead("d5");
        expect_frame("d5", {9'b0, 1'b1, 5'h13, 1'b0}, 7, 0);
        expect_idle("d5", 5);
        use5 = 1'b0;

        // Reset during data bit 3 of 0x81 (a 0 on the line) with two words queued.
        push(1'b0, 9'h081, acc);
        push(1'b0, 9'h042, acc);
        push(1'b0, 9'h024, acc);
        check("rstmid level", 32'(level8), 2);
        repeat (40) @(posedge clk);
        #3;
        check("rstmid txd before", 32'(txd8), 0);
        rst_n = 1'b0;
        #1;
        check("rstmid txd",   32'(txd8),   1);
        check("rstmid level", 32'(level8), 0);
        check("rstmid busy",  32'(busy8),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_idle("rstmid", 20);
        check("rstmid level after", 32'(level8), 0);
        push(1'b0, 9'h0C3, acc);
        check("post accepted", 32'(acc), 1);
        expect_lead("post");
        expect_frame("post", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 0);
        expect_idle("post", 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
